// File: rtl/pd_lock_seq.sv
// Lock sequencer for the phase-detector loop: acquire/lock/track/fault FSM driving the detector window.
// All outputs registered; width_win moves with state, delay_len follows one clock later.
module pd_lock_seq #(
  parameter int         WIDTH_TMR  = 21,
  parameter int         WIDTH_ERR  = 22,
  parameter logic [9:0] WIN_ACQ    = 10'd1000,
  parameter logic [9:0] WIN_TRK    = 10'd64,
  parameter int         LOCK_THR   = 1024,
  parameter int         UNLOCK_THR = 4096,
  parameter int         LOCK_CNT   = 8,
  parameter int         UNLOCK_CNT = 4,
  parameter int         WD_CYC     = 2500000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [WIDTH_TMR-1:0]        period_in,
  input  logic                        sample_in,
  input  logic signed [WIDTH_ERR-1:0] err_in,
  output logic [9:0]                  width_win,
  output logic [WIDTH_TMR-1:0]        delay_len,
  output logic                        loop_en,
  output logic                        locked,
  output logic                        lock_lost,
  output logic                        fault,
  output logic [1:0]                  state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [21:0] WD_MAX = 22'(WD_CYC);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2, FAULT = 2'd3} state_t;

  state_t                 cur_state, nxt_state;
  logic [GW-1:0]          good_cnt, good_nxt, good_inc;
  logic [BW-1:0]          bad_cnt, bad_nxt, bad_inc;
  logic [21:0]            wd_cnt, wd_nxt;
  logic [WIDTH_ERR-1:0]   abs_err;
  logic [WIDTH_TMR-1:0]   half_win, delay_nxt;

  assign state = cur_state;

  // The most negative error has no positive twin, so it clamps to the largest magnitude.
  always_comb begin
    if (err_in == {1'b1, {(WIDTH_ERR-1){1'b0}}})
      abs_err = {1'b0, {(WIDTH_ERR-1){1'b1}}};
    else if (err_in[WIDTH_ERR-1])
      abs_err = $unsigned(-err_in);
    else
      abs_err = $unsigned(err_in);
  end

  assign good_inc = (good_cnt == GW'(LOCK_CNT))   ? good_cnt : good_cnt + 1'b1;
  assign bad_inc  = (bad_cnt  == BW'(UNLOCK_CNT)) ? bad_cnt  : bad_cnt + 1'b1;

  assign half_win  = WIDTH_TMR'(width_win[9:1]);
  assign delay_nxt = (period_in <= half_win) ? WIDTH_TMR'(1) : period_in - half_win;

  always_comb begin
    nxt_state = cur_state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    wd_nxt    = wd_cnt;
    case (cur_state)
      IDLE: begin
        good_nxt = '0;
        bad_nxt  = '0;
        wd_nxt   = '0;
        nxt_state = ACQ;
      end
      ACQ, LOCK: begin
        if (sample_in) begin
          wd_nxt = '0;
          if (cur_state == ACQ) begin
            if (abs_err <= WIDTH_ERR'(LOCK_THR)) begin
              good_nxt = good_inc;
              if (good_inc == GW'(LOCK_CNT)) begin
                nxt_state = LOCK;
                bad_nxt   = '0;
              end
            end else begin
              good_nxt = '0;
            end
          end else begin
            if (abs_err > WIDTH_ERR'(UNLOCK_THR)) begin
              bad_nxt = bad_inc;
              if (bad_inc == BW'(UNLOCK_CNT)) begin
                nxt_state = ACQ;
                good_nxt  = '0;
              end
            end else begin
              bad_nxt = '0;
            end
          end
        end else if (wd_cnt == WD_MAX) begin
          nxt_state = FAULT;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      default: wd_nxt = '0;
    endcase
    // Dropping enable overrides everything else, including an idle-state start.
    if (!enable) nxt_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      wd_cnt    <= '0;
      width_win <= WIN_ACQ;
      delay_len <= '0;
      loop_en   <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      wd_cnt    <= wd_nxt;
      width_win <= (nxt_state == LOCK) ? WIN_TRK : WIN_ACQ;
      delay_len <= delay_nxt;
      loop_en   <= (nxt_state == ACQ) || (nxt_state == LOCK);
      locked    <= (nxt_state == LOCK);
      lock_lost <= (cur_state == LOCK) && (nxt_state == ACQ);
      fault     <= (nxt_state == FAULT);
    end
  end

endmodule
